mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single byte-wide RAM port between the instruction fetcher and the store/load buffer. Each granted access is sequenced byte by byte, little-endian, into or out of a 32-bit word, and completion is returned with a one-cycle done pulse. Reads are flushed on a ROB exception; committed stores always complete. Sits between the fetcher/SLB and the top-level RAM/IO pins.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, requester data width
- IO_HI, 2'b11, value of addr[17:16] that marks the IO region
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  ROB exception; aborts reads
- if_req  in  1  fetcher read request, level; held until if_done
- if_addr  in  ADDR_W  fetch address; always a 4-byte read
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  DATA_W  fetched word
- ls_req  in  1  SLB request, level; held until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  access address
- ls_wdata  in  DATA_W  store data, low bytes used
- ls_size  in  2  00 = word, 01 = byte, 10 = half, 11 = treated as word
- ls_done  out  1  one-cycle pulse; ls_rdata valid for loads
- ls_rdata  out  DATA_W  load data, zero-extended; SLB sign-extends
- ls_busy  out  1  high whenever state is not IDLE
- io_buffer_full  in  1  UART FIFO full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM address
- mem_wr  out  1  1 = write

## Operation
- Byte count n: 4 for if and for ls_size 00/11, 2 for 10, 1 for 01.
- States:
  - IDLE
  - READ: serves if or ls; the owner is held in a 1-bit `owner` register.
  - WRITE: serves ls only.
- IDLE grant rules:
  - Only one requester pending: grant it.
  - Both pending: grant the one not served last (1-bit `last` register). The reset value of `last` means ls is granted first.
  - A requester whose done is high this cycle is not eligible.
  - An ls write whose address has addr[17:16] == IO_HI is not eligible while io_buffer_full = 1. It stays pending, and if may be granted instead.
  - While flush = 1, nothing is granted.
- READ:
  - Byte counter k runs 0..n-1; mem_a = base + k.
  - Byte k is captured from mem_din into bits [8k+7:8k] one cycle after its address is driven. The RAM registers the address at the edge and presents data in the next cycle.
  - Unused upper bytes are 0.
- WRITE: mem_wr = 1, mem_a = base + k, mem_dout = ls_wdata[8k+7:8k], for k = 0..n-1, one byte per cycle.
- Address arithmetic is ADDR_W-bit with wrap; no alignment check.
- flush:
  - flush in READ: return to IDLE next edge with no done; the partial data is discarded.
  - flush in WRITE: ignored. The write completes and ls_done pulses.
  - flush in IDLE: no grant that cycle.
- Simultaneous flush and the final-byte edge of a read: the flush wins, and no done is issued.
- rst at any time: immediately return to IDLE and drop all outputs to their reset values. A partial write is abandoned.

## Timing
- Reset values:
  - state IDLE, last = if, k = 0
  - mem_wr 0, mem_a 0, mem_dout 0
  - if_done 0, ls_done 0, if_data 0, ls_rdata 0, ls_busy 0
- All outputs are registered.
- In IDLE, mem_a = 0 and mem_wr = 0.
- Read latency. Grant is at edge E0, where the request is sampled in IDLE.
  - mem_a = base + k is driven after edge E(k).
  - Byte k is captured at E(k+2).
  - done and data are registered at E(n+1), so done is high during cycle n+1.
  - The state is IDLE again after E(n+1).
  - Word read: 5 cycles from the request being sampled to done visible.
- Write latency. Grant is at E0.
  - Byte k is on the bus after E(k).
  - At E(n): mem_wr drops and done = 1.
  - Word write: done visible in cycle 4.
- Back-to-back: the earliest next grant is at the edge where done is high, and only to the other requester.
- if_data and ls_rdata hold their value until the next done for that requester.

## Structure
- Shared package:
  - size codes SZ_WORD/SZ_BYTE/SZ_HALF
  - IO_HI region constant
  - state encoding IDLE/READ/WRITE
  - owner encoding OWN_IF/OWN_LS
- Single module, no sub-module. The byte lane select/insert is an inline shift by {k, 3'b000}.

## Test plan
- if_req with if_addr 0x100, RAM bytes 13,00,00,00 -> mem_a 0x100..0x103 on successive cycles; if_done in cycle 5 with if_data 0x00000013.
- ls load with size 01 at addr 0x2003, RAM byte 0xF0 -> ls_done in cycle 2 with ls_rdata 0x000000F0; only one mem_a beat.
- ls store with size 10, wdata 0xAABBCCDD, addr 0x400 -> mem_wr pulses for writes 0xDD@0x400 and 0xCC@0x401; ls_done in cycle 2; RAM unchanged at 0x402.
- if_req and ls_req high together from reset -> ls granted first; after ls_done, if granted on the done cycle; the next collision grants ls.
- Store to 0x30000 with io_buffer_full = 1 for 10 cycles while if_req is high -> fetches proceed and no IO write; the store starts on the first grant cycle after full drops.
- flush in cycle 2 of a word load, then flush in cycle 1 of a word store -> the load returns to IDLE with no ls_done; the store writes all 4 bytes and ls_done pulses.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared definitions: access sizes, IO region,
// arbiter state and owner encodings, byte-count helper.
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    localparam logic [1:0] IO_HI_REGION = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // Number of RAM byte beats for an access of the given size.
    function automatic logic [2:0] byte_count(
        input logic [1:0] size
    );
        logic [2:0] n;
        unique case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between fetcher and SLB.
// Sequences little-endian word/half/byte accesses, one byte per cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [1:0] IO_HI  = IO_HI_REGION
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [1:0]        ls_size,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_busy,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    state_t            r_state;
    state_t            w_state_nx;
    owner_t            r_owner;
    owner_t            w_owner_nx;
    owner_t            r_last;
    owner_t            w_last_nx;
    // r_k is the index of the edge about to occur, counted from grant
    logic [2:0]        r_k;
    logic [2:0]        w_k_nx;
    logic [2:0]        r_n;
    logic [2:0]        w_n_nx;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] w_base_nx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nx;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_acc_nx;
    logic [ADDR_W-1:0] r_mem_a;
    logic [ADDR_W-1:0] w_mem_a_nx;
    logic [7:0]        r_mem_dout;
    logic [7:0]        w_mem_dout_nx;
    logic              r_mem_wr;
    logic              w_mem_wr_nx;
    logic              r_if_done;
    logic              w_if_done_nx;
    logic              r_ls_done;
    logic              w_ls_done_nx;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] w_if_data_nx;
    logic [DATA_W-1:0] r_ls_rdata;
    logic [DATA_W-1:0] w_ls_rdata_nx;
    logic              r_busy;
    logic              w_busy_nx;

    logic              w_if_ok;
    logic              w_io_blk;
    logic              w_ls_ok;
    logic              w_grant;
    logic              w_pick_ls;
    logic [2:0]        w_cap_idx;
    logic [DATA_W-1:0] w_byte_ext;
    logic [DATA_W-1:0] w_acc_cap;
    logic [DATA_W-1:0] w_rd_acc;
    logic [7:0]        w_wbyte;
    logic [ADDR_W-1:0] w_k_addr;

    // A requester whose done is showing is still holding req; skip it.
    assign w_if_ok   = if_req && !r_if_done;
    assign w_io_blk  = ls_we && (ls_addr[17:16] == IO_HI)
                       && io_buffer_full;
    assign w_ls_ok   = ls_req && !r_ls_done && !w_io_blk;
    assign w_grant   = !flush && (w_if_ok || w_ls_ok);
    assign w_pick_ls = w_ls_ok && (!w_if_ok || r_last == OWN_IF);

    // RAM data lags its address by two edges.
    assign w_cap_idx  = r_k - 3'd2;
    assign w_byte_ext = DATA_W'(mem_din);
    assign w_acc_cap  = r_acc
                        | (w_byte_ext << {w_cap_idx, 3'b000});
    assign w_rd_acc   = (r_k >= 3'd2) ? w_acc_cap : r_acc;
    assign w_wbyte    = 8'(r_wdata >> {r_k, 3'b000});
    assign w_k_addr   = r_base + ADDR_W'(r_k);

    // Next-state, grant and byte sequencing for all registered outputs.
    always_comb begin
        w_state_nx    = r_state;
        w_owner_nx    = r_owner;
        w_last_nx     = r_last;
        w_k_nx        = r_k;
        w_n_nx        = r_n;
        w_base_nx     = r_base;
        w_wdata_nx    = r_wdata;
        w_acc_nx      = r_acc;
        w_mem_a_nx    = r_mem_a;
        w_mem_dout_nx = r_mem_dout;
        w_mem_wr_nx   = 1'b0;
        w_if_done_nx  = 1'b0;
        w_ls_done_nx  = 1'b0;
        w_if_data_nx  = r_if_data;
        w_ls_rdata_nx = r_ls_rdata;

        unique case (r_state)
            IDLE: begin
                w_mem_a_nx = '0;
                if (w_grant) begin
                    w_k_nx   = 3'd1;
                    w_acc_nx = '0;
                    if (w_pick_ls) begin
                        w_owner_nx = OWN_LS;
                        w_last_nx  = OWN_LS;
                        w_base_nx  = ls_addr;
                        w_wdata_nx = ls_wdata;
                        w_n_nx     = byte_count(ls_size);
                        w_mem_a_nx = ls_addr;
                        if (ls_we) begin
                            w_state_nx    = WRITE;
                            w_mem_wr_nx   = 1'b1;
                            w_mem_dout_nx = ls_wdata[7:0];
                        end else begin
                            w_state_nx = READ;
                        end
                    end else begin
                        w_owner_nx = OWN_IF;
                        w_last_nx  = OWN_IF;
                        w_base_nx  = if_addr;
                        w_n_nx     = 3'd4;
                        w_mem_a_nx = if_addr;
                        w_state_nx = READ;
                    end
                end
            end

            READ: begin
                if (flush) begin
                    w_state_nx = IDLE;
                    w_k_nx     = 3'd0;
                    w_mem_a_nx = '0;
                end else if (r_k == r_n + 3'd1) begin
                    w_state_nx = IDLE;
                    w_k_nx     = 3'd0;
                    w_mem_a_nx = '0;
                    if (r_owner == OWN_LS) begin
                        w_ls_done_nx  = 1'b1;
                        w_ls_rdata_nx = w_rd_acc;
                    end else begin
                        w_if_done_nx = 1'b1;
                        w_if_data_nx = w_rd_acc;
                    end
                end else begin
                    w_acc_nx = w_rd_acc;
                    w_k_nx   = r_k + 3'd1;
                    if (r_k < r_n) begin
                        w_mem_a_nx = w_k_addr;
                    end
                end
            end

            WRITE: begin
                if (r_k == r_n) begin
                    w_state_nx    = IDLE;
                    w_k_nx        = 3'd0;
                    w_mem_a_nx    = '0;
                    w_mem_dout_nx = 8'h00;
                    w_ls_done_nx  = 1'b1;
                end else begin
                    w_mem_wr_nx   = 1'b1;
                    w_mem_a_nx    = w_k_addr;
                    w_mem_dout_nx = w_wbyte;
                    w_k_nx        = r_k + 3'd1;
                end
            end

            default: begin
                w_state_nx = IDLE;
                w_k_nx     = 3'd0;
                w_mem_a_nx = '0;
            end
        endcase

        w_busy_nx = (w_state_nx != IDLE);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_IF;
            r_last     <= OWN_IF;
            r_k        <= 3'd0;
            r_n        <= 3'd0;
            r_base     <= '0;
            r_wdata    <= '0;
            r_acc      <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= 8'h00;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= '0;
            r_ls_rdata <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_owner    <= w_owner_nx;
            r_last     <= w_last_nx;
            r_k        <= w_k_nx;
            r_n        <= w_n_nx;
            r_base     <= w_base_nx;
            r_wdata    <= w_wdata_nx;
            r_acc      <= w_acc_nx;
            r_mem_a    <= w_mem_a_nx;
            r_mem_dout <= w_mem_dout_nx;
            r_mem_wr   <= w_mem_wr_nx;
            r_if_done  <= w_if_done_nx;
            r_ls_done  <= w_ls_done_nx;
            r_if_data  <= w_if_data_nx;
            r_ls_rdata <= w_ls_rdata_nx;
            r_busy     <= w_busy_nx;
        end
    end

    assign if_done  = r_if_done;
    assign if_data  = r_if_data;
    assign ls_done  = r_ls_done;
    assign ls_rdata = r_ls_rdata;
    assign ls_busy  = r_busy;
    assign mem_a    = r_mem_a;
    assign mem_wr   = r_mem_wr;
    assign mem_dout = r_mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, transaction-level reference
// model compared every cycle, plus directed literal checks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [1:0]  ls_size;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_busy;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int io_wr_full = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_size(ls_size),
        .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_busy(ls_busy),
        .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered address, data one cycle later; writes at edge
    logic [7:0] ram [0:262143];
    logic       filled = 1'b0;

    function automatic logic [7:0] init_byte(input logic [17:0] a);
        case (a)
            18'h00100: return 8'h13;
            18'h00101: return 8'h00;
            18'h00102: return 8'h00;
            18'h00103: return 8'h00;
            18'h02003: return 8'hF0;
            18'h00402: return 8'h11;
            default:   return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 262144; i++)
                ram[i] <= init_byte(18'(i));
            filled <= 1'b1;
        end else begin
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
            mem_din <= ram[mem_a[17:0]];
        end
    end

    always @(posedge clk)
        if (mem_wr && mem_a[17:16] == 2'b11 && io_buffer_full)
            io_wr_full <= io_wr_full + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] b,
                                               input int n);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < n; i++)
            w |= 32'(ram[18'(b + 32'(i))]) << (8 * i);
        return w;
    endfunction

    // Transaction-level model: a granted access occupies a fixed
    // window of edges after its grant edge.
    logic [31:0] e_mem_a, e_if_data, e_ls_rdata;
    logic [7:0]  e_dout;
    logic        e_mem_wr, e_if_done, e_ls_done, e_busy, a_chk;
    logic        m_act, m_we, m_own, m_last;
    int          m_j, m_n;
    logic [31:0] m_base, m_wd;

    initial begin
        logic p_if, p_ls, ifok, lsok;
        logic [31:0] w;
        m_act = 0; m_last = 0; a_chk = 1;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_act = 0; m_last = 0; a_chk = 1;
                e_mem_a = 0; e_dout = 0; e_mem_wr = 0;
                e_if_done = 0; e_ls_done = 0;
                e_if_data = 0; e_ls_rdata = 0; e_busy = 0;
            end else begin
                p_if = e_if_done;
                p_ls = e_ls_done;
                e_if_done = 0; e_ls_done = 0;
                e_mem_wr = 0; a_chk = 1;
                if (m_act) begin
                    m_j++;
                    if (!m_we) begin
                        if (flush) begin
                            m_act = 0; e_mem_a = 0;
                        end else if (m_j == m_n + 1) begin
                            w = model_word(m_base, m_n);
                            if (m_own) begin
                                e_ls_done = 1; e_ls_rdata = w;
                            end else begin
                                e_if_done = 1; e_if_data = w;
                            end
                            m_act = 0; e_mem_a = 0;
                        end else if (m_j < m_n) begin
                            e_mem_a = m_base + 32'(m_j);
                        end else begin
                            a_chk = 0;
                        end
                    end else begin
                        if (m_j == m_n) begin
                            e_ls_done = 1; m_act = 0; e_mem_a = 0;
                        end else begin
                            e_mem_wr = 1;
                            e_mem_a = m_base + 32'(m_j);
                            e_dout = 8'(m_wd >> (8 * m_j));
                        end
                    end
                end else begin
                    e_mem_a = 0;
                    ifok = if_req && !p_if;
                    lsok = ls_req && !p_ls &&
                           !(ls_we && ls_addr[17:16] == 2'b11 &&
                             io_buffer_full);
                    if (!flush && (ifok || lsok)) begin
                        m_act = 1; m_j = 0;
                        if (lsok && (!ifok || !m_last)) begin
                            m_own = 1; m_last = 1; m_we = ls_we;
                            m_base = ls_addr; m_wd = ls_wdata;
                            m_n = (ls_size == 2'b01) ? 1 :
                                  (ls_size == 2'b10) ? 2 : 4;
                        end else begin
                            m_own = 0; m_last = 0; m_we = 0;
                            m_base = if_addr; m_n = 4;
                        end
                        e_mem_a = m_base;
                        if (m_we) begin
                            e_mem_wr = 1; e_dout = m_wd[7:0];
                        end
                    end
                end
                e_busy = m_act;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("mem_wr", mem_wr, e_mem_wr);
                if (a_chk) chk("mem_a", mem_a, e_mem_a);
                if (e_mem_wr) chk("mem_dout", mem_dout, e_dout);
                chk("if_done", if_done, e_if_done);
                chk("ls_done", ls_done, e_ls_done);
                chk("if_data", if_data, e_if_data);
                chk("ls_rdata", ls_rdata, e_ls_rdata);
                chk("ls_busy", ls_busy, e_busy);
            end
        end
    end

    task automatic wait_done(input bit is_ls, input int t0,
                             output int lat);
        lat = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if ((is_ls && ls_done) || (!is_ls && if_done)) begin
                lat = cyc - t0 - 1;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout ls=%0d got=none want=done",
                     is_ls);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int exp_lat,
                         input logic [31:0] exp_d);
        int t0, lat;
        if_addr = a;
        if_req = 1;
        t0 = cyc;
        wait_done(0, t0, lat);
        if_req = 0;
        if (exp_lat >= 0) chk("if_lat", lat, exp_lat);
        chk("if_word", if_data, exp_d);
    endtask

    task automatic lsop(input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_d);
        int t0, lat;
        ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
        ls_req = 1;
        t0 = cyc;
        wait_done(1, t0, lat);
        ls_req = 0;
        if (exp_lat >= 0) chk("ls_lat", lat, exp_lat);
        if (!we) chk("ls_word", ls_rdata, exp_d);
    endtask

    task automatic flush_read(input int at);
        logic seen;
        seen = 0;
        ls_we = 0; ls_size = 2'b00; ls_addr = 32'h2000;
        ls_req = 1;
        repeat (at + 1) begin
            @(negedge clk);
            seen |= ls_done;
        end
        flush = 1;
        @(negedge clk);
        seen |= ls_done;
        flush = 0;
        ls_req = 0;
        repeat (6) begin
            @(negedge clk);
            seen |= ls_done;
        end
        chk("flush_nodone", seen, 0);
        chk("flush_idle", ls_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; flush = 0; if_req = 0; if_addr = 0;
        ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
        ls_size = 0; io_buffer_full = 0;
        repeat (3) @(negedge clk);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_ls_done", ls_done, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        chk("rst_ls_busy", ls_busy, 0);
        rst = 0;
        @(negedge clk);

        fetch(32'h100, 5, 32'h00000013);
        @(negedge clk);
        lsop(0, 2'b01, 32'h2003, 0, 2, 32'h000000F0);
        @(negedge clk);
        lsop(1, 2'b10, 32'h400, 32'hAABBCCDD, 2, 0);
        @(negedge clk);
        chk("ram_400", ram[18'h400], 8'hDD);
        chk("ram_401", ram[18'h401], 8'hCC);
        chk("ram_402", ram[18'h402], 8'h11);

        rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        fork
            lsop(0, 2'b00, 32'h2000, 0, 5, 32'hF0585B5A);
            fetch(32'h100, 11, 32'h00000013);
        join
        repeat (2) @(negedge clk);
        fork
            lsop(0, 2'b11, 32'h2000, 0, 5, 32'hF0585B5A);
            fetch(32'h100, 11, 32'h00000013);
        join
        repeat (2) @(negedge clk);

        io_buffer_full = 1;
        fork
            lsop(1, 2'b00, 32'h30000, 32'h12345678, -1, 0);
            begin
                repeat (3) fetch(32'h100, -1, 32'h00000013);
            end
            begin
                repeat (10) @(negedge clk);
                io_buffer_full = 0;
            end
        join
        @(negedge clk);
        chk("io_wr_full", io_wr_full, 0);
        chk("ram_30000", ram[18'h30000], 8'h78);
        chk("ram_30003", ram[18'h30003], 8'h12);

        flush_read(2);
        flush_read(4);
        fork
            lsop(0, 2'b01, 32'h2003, 0, 4, 32'h000000F0);
            begin
                flush = 1;
                repeat (2) @(negedge clk);
                flush = 0;
            end
        join
        @(negedge clk);
        fork
            lsop(1, 2'b00, 32'h500, 32'hCAFEBABE, 4, 0);
            begin
                repeat (2) @(negedge clk);
                flush = 1;
                @(negedge clk);
                flush = 0;
            end
        join
        @(negedge clk);
        chk("ram_500", ram[18'h500], 8'hBE);
        chk("ram_503", ram[18'h503], 8'hCA);

        ls_we = 1; ls_size = 2'b00; ls_addr = 32'h600;
        ls_wdata = 32'h01020304; ls_req = 1;
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        chk("arst_mem_wr", mem_wr, 0);
        chk("arst_mem_a", mem_a, 0);
        chk("arst_busy", ls_busy, 0);
        ls_req = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("ram_601", ram[18'h601], 8'h5B);
        fetch(32'h100, 5, 32'h00000013);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
